// File: rtl/aes128_dec_pipe_if.sv
// Block/key/plaintext bundle for the AES-128 decryption pipeline.
// The core side takes the slave modport; the block source takes the master modport.
interface aes128_dec_pipe_if;
    logic [127:0] ciphertext;
    logic [127:0] key10;
    logic [127:0] plaintext;

    modport master (output ciphertext, output key10, input plaintext);
    modport slave  (input ciphertext, input key10, output plaintext);
endinterface

// File: rtl/aes128_dec_pipe.sv
// AES-128 inverse cipher, fully pipelined; round keys derived backward from key10 alongside each block.
// Latency 59 edges (capture to plaintext register), one block per cycle, no valid flag.
// No backpressure, never stalls. Define AES_DEC_DATAPATH_RESET_EN to async-reset every inner stage too.
module aes128_dec_pipe (
    input  logic            clk,
    input  logic            rst,
    aes128_dec_pipe_if.slave bus
);
    localparam int NSTG = 58;

    typedef struct packed {
        logic [127:0] state;
        logic [127:0] key;
    } stage_t;

    stage_t       pipe [NSTG];
    stage_t       nxt  [NSTG];
    logic [127:0] pt_q;
    logic [127:0] k0;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r)&3)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] aff_inv_all(input logic [127:0] s);
        logic [127:0] o;
        for (int b = 0; b < 16; b++) o[8*b +: 8] = aff_inv(s[8*b +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] gf_inv_all(input logic [127:0] s);
        logic [127:0] o;
        for (int b = 0; b < 16; b++) o[8*b +: 8] = gf_inv(s[8*b +: 8]);
        return o;
    endfunction

    // InvMixColumns = MixColumns after this per-column pre-mix, giving a clean 2-stage split.
    function automatic logic [127:0] imc_pre(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   u, v;
        for (int c = 0; c < 4; c++) begin
            u = xt(xt(s[127-32*c -: 8] ^ s[111-32*c -: 8]));
            v = xt(xt(s[119-32*c -: 8] ^ s[103-32*c -: 8]));
            o[127-32*c -: 32] = s[127-32*c -: 32] ^ {u, v, u, v};
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

    // Rcon used when round key r+1 was expanded from round key r.
    function automatic logic [7:0] rcon_of(input int r);
        case (r)
            9:       return 8'h36;
            8:       return 8'h1b;
            7:       return 8'h80;
            6:       return 8'h40;
            5:       return 8'h20;
            4:       return 8'h10;
            3:       return 8'h08;
            2:       return 8'h04;
            1:       return 8'h02;
            0:       return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_back(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        t  = {w3[23:0], w3[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        w0 = k[127:96] ^ t ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

    assign nxt[0] = {bus.ciphertext ^ bus.key10, bus.key10};

    for (genvar j = 0; j < 9; j++) begin : g_round
        localparam int BASE = 1 + 6 * j;
        logic [127:0] rk;

        assign rk          = key_back(pipe[BASE+2].key, rcon_of(9 - j));
        assign nxt[BASE]   = {inv_shift_rows(pipe[BASE-1].state), pipe[BASE-1].key};
        assign nxt[BASE+1] = {aff_inv_all(pipe[BASE].state), pipe[BASE].key};
        assign nxt[BASE+2] = {gf_inv_all(pipe[BASE+1].state), pipe[BASE+1].key};
        assign nxt[BASE+3] = {pipe[BASE+2].state ^ rk, rk};
        assign nxt[BASE+4] = {imc_pre(pipe[BASE+3].state), pipe[BASE+3].key};
        assign nxt[BASE+5] = {mix_columns(pipe[BASE+4].state), pipe[BASE+4].key};
    end

    assign nxt[55] = {inv_shift_rows(pipe[54].state), pipe[54].key};
    assign nxt[56] = {aff_inv_all(pipe[55].state), pipe[55].key};
    assign nxt[57] = {gf_inv_all(pipe[56].state), pipe[56].key};
    assign k0      = key_back(pipe[57].key, rcon_of(0));

`ifdef AES_DEC_DATAPATH_RESET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSTG; i++) pipe[i] <= '0;
        end else begin
            for (int i = 0; i < NSTG; i++) pipe[i] <= nxt[i];
        end
    end
`else
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSTG; i++) pipe[i] <= nxt[i];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pt_q <= '0;
        else     pt_q <= pipe[57].state ^ k0;
    end

    assign bus.plaintext = pt_q;
endmodule

// File: tb/tb_aes128_dec_pipe.sv
// Scoreboard bench for aes128_dec_pipe: stimulus queues expected plaintexts with their due cycle,
// a negedge monitor pops and compares them against known AES-128 vectors.
module tb_aes128_dec_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    aes128_dec_pipe_if bus();

    aes128_dec_pipe dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] val;
        int           due;
        bit           neq;
        string        name;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;

    logic [127:0] ct_s [5];
    logic [127:0] pt_s [5];

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] want, input bit neq);
        n_tests++;
        if (neq ? (got == want) : (got !== want)) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: plaintext %h, required %s%h",
                     name, cyc, got, neq ? "anything but " : "", want);
        end
    endtask

    exp_t e;
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            if (e.due < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: check missed, due cycle %0d, now %0d", e.name, e.due, cyc);
            end else begin
                check(e.name, bus.plaintext, e.val, e.neq);
            end
        end
    end

    task automatic drive(input logic [127:0] ct, input logic [127:0] k);
        @(negedge clk);
        bus.ciphertext = ct;
        bus.key10      = k;
    endtask

    task automatic expect_at(input int d, input logic [127:0] v, input bit neq, input string name);
        exp_t x;
        x.val  = v;
        x.due  = cyc + d;
        x.neq  = neq;
        x.name = name;
        sbq.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected outputs never checked, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        ct_s = '{128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hf5d3d58503b9699de785895a96fdbaaf,
                 128'h43b1cd7f598ece23881b00e3ed030688, 128'h7b0c785e27e8ad3f8223207104725dd4, CT_B};
        pt_s = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                 128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710, PT_B};
        bus.ciphertext = '0;
        bus.key10      = '0;
        #1 rst = 1'b1;
        #1 check("reset_init", bus.plaintext, '0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) drive('0, '0);

        // Single FIPS-197 C.1 block: absent after 58 edges, present after 59.
        drive(CT_C, K_C);
        expect_at(58, PT_C, 1'b1, "c1_not_at_58");
        expect_at(59, PT_C, 1'b0, "c1_at_59");
        drive('0, '0);
        drive(CT_B, K_B);
        expect_at(59, PT_B, 1'b0, "fips_b");
        drive('0, '0);
        drain();

        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                drive(CT_B, K_B);
                expect_at(59, PT_B, 1'b0, "b2b_b");
            end else begin
                drive(CT_C, K_C);
                expect_at(59, PT_C, 1'b0, "b2b_c1");
            end
        end
        drive('0, '0);
        drain();

        for (int i = 0; i < 24; i++) begin
            drive(ct_s[i % 5], K_B);
            expect_at(59, pt_s[i % 5], 1'b0, "stream");
        end
        drive('0, '0);
        drain();

        // Asynchronous reset mid-cycle, then held for 10 edges.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async", bus.plaintext, '0, 1'b0);
        for (int d = 1; d <= 10; d++) expect_at(d, '0, 1'b0, "rst_hold");
        repeat (11) @(negedge clk);
        rst = 1'b0;
        repeat (3) drive('0, '0);

        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) drive(CT_B, K_B);
            else            drive(CT_C, K_C);
        end
        @(negedge clk);
        bus.ciphertext = '0;
        bus.key10      = '0;
        rst = 1'b1;
        #1 check("rst_mid", bus.plaintext, '0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
`ifdef AES_DEC_DATAPATH_RESET_EN
        for (int d = 1; d <= 70; d++) begin
            expect_at(d, PT_B, 1'b1, "no_leak_b");
            expect_at(d, PT_C, 1'b1, "no_leak_c1");
        end
`endif
        repeat (75) drive('0, '0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end
endmodule
